// File: rtl/periph_bus_bridge.sv
// ---------------------------------------------------------------------------
// periph_bus_bridge
//
// Purpose:
//   Address decoder and handshake bridge between the picorv32 native memory
//   port and up to four memory-mapped peripheral slots. One address window
//   starting at BASE_ADDR is split into four slots of 2**SLOT_BITS bytes each.
//   A hit on a populated slot is forwarded as a registered request to the
//   peripherals. A hit on an unpopulated slot, or a slave that does not answer
//   within TIMEOUT cycles, is ended with an error response. That way the CPU
//   never stalls forever. Misses are left to whatever other decoder owns them.
//
// Ports:
//   clk, reset          clock (rising edge) and synchronous active-high reset
//   cpu_valid/instr/wstrb/wdata/addr   picorv32 native request
//   cpu_ready           one-cycle completion pulse
//   cpu_rdata           registered read data; held between responses
//   per_valid           request valid to peripherals
//   per_enable[3:0]     one-hot slot select
//   per_instr/wstrb/wdata/addr         registered copies of the request
//   per_ready[3:0]      per-slot ready
//   per_rdata[127:0]    per-slot read data, slot i on [32i+31:32i]
//   bus_err             one-cycle pulse on each error termination
//   err_addr            address of the most recent error
//   err_count           saturating error counter
// ---------------------------------------------------------------------------
module periph_bus_bridge #(
    parameter logic [31:0] BASE_ADDR = 32'h0200_0000,
    parameter int unsigned SLOT_BITS = 8,
    parameter logic [3:0]  SLOT_MASK = 4'b0001,
    parameter int unsigned TIMEOUT   = 255,
    parameter logic [31:0] ERR_DATA  = 32'hDEAD_BEEF
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         cpu_valid,
    input  logic         cpu_instr,
    input  logic [3:0]   cpu_wstrb,
    input  logic [31:0]  cpu_wdata,
    input  logic [31:0]  cpu_addr,
    output logic         cpu_ready,
    output logic [31:0]  cpu_rdata,
    output logic         per_valid,
    output logic [3:0]   per_enable,
    output logic         per_instr,
    output logic [3:0]   per_wstrb,
    output logic [31:0]  per_wdata,
    output logic [31:0]  per_addr,
    input  logic [3:0]   per_ready,
    input  logic [127:0] per_rdata,
    output logic         bus_err,
    output logic [31:0]  err_addr,
    output logic [7:0]   err_count
);

    localparam int unsigned WIN_LSB     = SLOT_BITS + 2;
    localparam logic [7:0]  TIMEOUT_LIM = 8'(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2,
        ERR    = 2'd3
    } state_t;

    state_t       state_q,     state_d;
    logic [7:0]   tmo_cnt_q,   tmo_cnt_d;
    logic [1:0]   slot_q,      slot_d;
    logic         cpu_ready_q, cpu_ready_d;
    logic [31:0]  cpu_rdata_q, cpu_rdata_d;
    logic         per_valid_q, per_valid_d;
    logic [3:0]   per_enable_q, per_enable_d;
    logic         per_instr_q, per_instr_d;
    logic [3:0]   per_wstrb_q, per_wstrb_d;
    logic [31:0]  per_wdata_q, per_wdata_d;
    logic [31:0]  per_addr_q,  per_addr_d;
    logic         bus_err_q,   bus_err_d;
    logic [31:0]  err_addr_q,  err_addr_d;
    logic [7:0]   err_count_q, err_count_d;

    // Per-slot read data split out of the flat bus.
    logic [31:0] slot_rdata [4];

    for (genvar gi = 0; gi < 4; gi++) begin : g_slot_rdata
        assign slot_rdata[gi] = per_rdata[32*gi +: 32];
    end

    logic       win_hit;
    logic [1:0] req_slot;
    logic [7:0] err_count_inc;

    assign win_hit       = (cpu_addr[31:WIN_LSB] == BASE_ADDR[31:WIN_LSB]);
    assign req_slot      = cpu_addr[WIN_LSB-1:SLOT_BITS];
    assign err_count_inc = (err_count_q == 8'hFF) ? 8'hFF : err_count_q + 8'd1;

    always_comb begin
        state_d      = state_q;
        tmo_cnt_d    = tmo_cnt_q;
        slot_d       = slot_q;
        cpu_ready_d  = 1'b0;
        cpu_rdata_d  = cpu_rdata_q;
        per_valid_d  = per_valid_q;
        per_enable_d = per_enable_q;
        per_instr_d  = per_instr_q;
        per_wstrb_d  = per_wstrb_q;
        per_wdata_d  = per_wdata_q;
        per_addr_d   = per_addr_q;
        bus_err_d    = 1'b0;
        err_addr_d   = err_addr_q;
        err_count_d  = err_count_q;

        case (state_q)
            IDLE: begin
                // The guard on cpu_ready_q keeps a valid that is still high
                // in the completion cycle from starting a second access.
                if (cpu_valid && win_hit && !cpu_ready_q) begin
                    per_addr_d  = cpu_addr;
                    per_wstrb_d = cpu_wstrb;
                    per_wdata_d = cpu_wdata;
                    per_instr_d = cpu_instr;
                    slot_d      = req_slot;
                    if (SLOT_MASK[req_slot]) begin
                        state_d      = ACCESS;
                        per_valid_d  = 1'b1;
                        per_enable_d = 4'b0001 << req_slot;
                        tmo_cnt_d    = 8'd0;
                    end else begin
                        // Error outputs are registered on entry so the CPU
                        // sees the response in the very next cycle.
                        state_d     = ERR;
                        cpu_ready_d = 1'b1;
                        bus_err_d   = 1'b1;
                        cpu_rdata_d = ERR_DATA;
                        err_addr_d  = cpu_addr;
                        err_count_d = err_count_inc;
                    end
                end
            end

            ACCESS: begin
                // Ready is checked first so that a slave answering on the
                // timeout edge still completes normally.
                if (per_ready[slot_q]) begin
                    state_d      = RESP;
                    cpu_ready_d  = 1'b1;
                    cpu_rdata_d  = slot_rdata[slot_q];
                    per_valid_d  = 1'b0;
                    per_enable_d = 4'b0000;
                end else if (tmo_cnt_q == TIMEOUT_LIM) begin
                    state_d      = ERR;
                    cpu_ready_d  = 1'b1;
                    bus_err_d    = 1'b1;
                    cpu_rdata_d  = ERR_DATA;
                    err_addr_d   = per_addr_q;
                    err_count_d  = err_count_inc;
                    per_valid_d  = 1'b0;
                    per_enable_d = 4'b0000;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 8'd1;
                    // The request is withdrawn as soon as the counter
                    // reaches the limit. This keeps per_valid high for
                    // exactly TIMEOUT cycles. The error follows on the next
                    // edge unless a late ready still arrives.
                    if (tmo_cnt_q + 8'd1 == TIMEOUT_LIM) begin
                        per_valid_d  = 1'b0;
                        per_enable_d = 4'b0000;
                    end
                end
            end

            RESP: begin
                state_d = IDLE;
            end

            ERR: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            tmo_cnt_q    <= 8'd0;
            slot_q       <= 2'd0;
            cpu_ready_q  <= 1'b0;
            cpu_rdata_q  <= 32'd0;
            per_valid_q  <= 1'b0;
            per_enable_q <= 4'd0;
            per_instr_q  <= 1'b0;
            per_wstrb_q  <= 4'd0;
            per_wdata_q  <= 32'd0;
            per_addr_q   <= 32'd0;
            bus_err_q    <= 1'b0;
            err_addr_q   <= 32'd0;
            err_count_q  <= 8'd0;
        end else begin
            state_q      <= state_d;
            tmo_cnt_q    <= tmo_cnt_d;
            slot_q       <= slot_d;
            cpu_ready_q  <= cpu_ready_d;
            cpu_rdata_q  <= cpu_rdata_d;
            per_valid_q  <= per_valid_d;
            per_enable_q <= per_enable_d;
            per_instr_q  <= per_instr_d;
            per_wstrb_q  <= per_wstrb_d;
            per_wdata_q  <= per_wdata_d;
            per_addr_q   <= per_addr_d;
            bus_err_q    <= bus_err_d;
            err_addr_q   <= err_addr_d;
            err_count_q  <= err_count_d;
        end
    end

    assign cpu_ready  = cpu_ready_q;
    assign cpu_rdata  = cpu_rdata_q;
    assign per_valid  = per_valid_q;
    assign per_enable = per_enable_q;
    assign per_instr  = per_instr_q;
    assign per_wstrb  = per_wstrb_q;
    assign per_wdata  = per_wdata_q;
    assign per_addr   = per_addr_q;
    assign bus_err    = bus_err_q;
    assign err_addr   = err_addr_q;
    assign err_count  = err_count_q;

endmodule

// File: tb/tb_periph_bus_bridge.sv
// ---------------------------------------------------------------------------
// tb_periph_bus_bridge
//
// Testbench for periph_bus_bridge. It drives directed and random CPU
// requests. Per-slot slave models answer after a chosen latency, or never.
// Each transaction is checked against a transaction-level model: hit or miss,
// populated or not, and whether the slave latency fits inside the timeout.
// ---------------------------------------------------------------------------
module tb_periph_bus_bridge;

    localparam logic [31:0] BASE      = 32'h0200_0000;
    localparam int          SBITS     = 8;
    localparam logic [3:0]  MASK      = 4'b1011;
    localparam int          TMO       = 4;
    localparam logic [31:0] ERRD      = 32'hDEAD_BEEF;

    logic         clk = 1'b0;
    logic         reset;
    logic         cpu_valid;
    logic         cpu_instr;
    logic [3:0]   cpu_wstrb;
    logic [31:0]  cpu_wdata;
    logic [31:0]  cpu_addr;
    logic         cpu_ready;
    logic [31:0]  cpu_rdata;
    logic         per_valid;
    logic [3:0]   per_enable;
    logic         per_instr;
    logic [3:0]   per_wstrb;
    logic [31:0]  per_wdata;
    logic [31:0]  per_addr;
    logic [3:0]   per_ready = 4'b0000;
    logic [127:0] per_rdata;
    logic         bus_err;
    logic [31:0]  err_addr;
    logic [7:0]   err_count;

    int checks = 0;
    int errors = 0;

    // Transaction-level expectations
    logic [31:0] exp_rdata;
    logic [31:0] exp_err_addr;
    int          exp_err_count;

    // Slave models: latency 0 means the slave never answers.
    int          slv_lat  [4];
    logic [31:0] slv_data [4];
    int          slv_cnt  [4];

    always #5 clk = ~clk;

    periph_bus_bridge #(
        .BASE_ADDR (BASE),
        .SLOT_BITS (SBITS),
        .SLOT_MASK (MASK),
        .TIMEOUT   (TMO),
        .ERR_DATA  (ERRD)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .cpu_valid  (cpu_valid),
        .cpu_instr  (cpu_instr),
        .cpu_wstrb  (cpu_wstrb),
        .cpu_wdata  (cpu_wdata),
        .cpu_addr   (cpu_addr),
        .cpu_ready  (cpu_ready),
        .cpu_rdata  (cpu_rdata),
        .per_valid  (per_valid),
        .per_enable (per_enable),
        .per_instr  (per_instr),
        .per_wstrb  (per_wstrb),
        .per_wdata  (per_wdata),
        .per_addr   (per_addr),
        .per_ready  (per_ready),
        .per_rdata  (per_rdata),
        .bus_err    (bus_err),
        .err_addr   (err_addr),
        .err_count  (err_count)
    );

    assign per_rdata = {slv_data[3], slv_data[2], slv_data[1], slv_data[0]};

    // A slave raises ready for one cycle, L cycles after it first sees its
    // request. It forgets the request as soon as the request is withdrawn.
    always @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (!reset && per_valid && per_enable[i]) begin
                slv_cnt[i]   <= slv_cnt[i] + 1;
                per_ready[i] <= (slv_lat[i] != 0) && (slv_cnt[i] + 1 == slv_lat[i]);
            end else begin
                slv_cnt[i]   <= 0;
                per_ready[i] <= 1'b0;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic bit is_hit(input logic [31:0] a);
        return (a >> (SBITS + 2)) == (BASE >> (SBITS + 2));
    endfunction

    // Request outside the window, held for 20 cycles; nothing may respond.
    task automatic do_miss(input logic [31:0] addr);
        cpu_addr  = addr;
        cpu_wstrb = 4'h0;
        cpu_wdata = 32'h0;
        cpu_instr = 1'b0;
        cpu_valid = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk); #1;
            check("miss_quiet", {29'd0, cpu_ready, per_valid, bus_err}, 32'd0);
        end
        cpu_valid = 1'b0;
        @(posedge clk); #1;
        $display("txn miss addr=%h quiet for 20 cycles", addr);
    endtask

    // One in-window transaction. The caller starts it in an IDLE cycle, #1
    // after a rising edge.
    task automatic do_txn(input logic [31:0] addr, input logic [3:0] wstrb,
                          input logic [31:0] wdata, input logic instr);
        int          s;
        int          lat;
        int          exp_cyc;
        int          exp_v;
        int          got_cyc;
        int          vcnt;
        bit          is_err;
        logic [31:0] held;
        s   = int'((addr >> SBITS) & 32'd3);
        lat = slv_lat[s];
        if (!MASK[s]) begin
            exp_cyc = 1; is_err = 1'b1; exp_v = 0;
        end else if (lat != 0 && lat <= TMO) begin
            exp_cyc = lat + 2; is_err = 1'b0;
            exp_v   = (lat + 1 < TMO) ? lat + 1 : TMO;
        end else begin
            exp_cyc = TMO + 2; is_err = 1'b1; exp_v = TMO;
        end

        cpu_addr  = addr;
        cpu_wstrb = wstrb;
        cpu_wdata = wdata;
        cpu_instr = instr;
        cpu_valid = 1'b1;
        got_cyc   = 0;
        vcnt      = 0;
        for (int c = 1; c <= 40 && got_cyc == 0; c++) begin
            @(posedge clk); #1;
            if (per_valid) vcnt++;
            if (c == 1 && MASK[s]) begin
                check("per_enable", {28'd0, per_enable}, 32'd1 << s);
                check("per_addr",   per_addr, addr);
                check("per_wdata",  per_wdata, wdata);
                check("per_wstrb",  {28'd0, per_wstrb}, {28'd0, wstrb});
                check("per_instr",  {31'd0, per_instr}, {31'd0, instr});
            end
            if (cpu_ready) got_cyc = c;
        end
        cpu_valid = 1'b0;

        if (is_err) begin
            exp_rdata    = ERRD;
            exp_err_addr = addr;
            if (exp_err_count < 255) exp_err_count++;
        end else begin
            exp_rdata = slv_data[s];
        end
        check("latency",      32'(got_cyc), 32'(exp_cyc));
        check("bus_err",      {31'd0, bus_err}, {31'd0, is_err});
        check("cpu_rdata",    cpu_rdata, exp_rdata);
        check("err_addr",     err_addr, exp_err_addr);
        check("err_count",    {24'd0, err_count}, 32'(exp_err_count));
        check("valid_cycles", 32'(vcnt), 32'(exp_v));

        held = exp_rdata;
        @(posedge clk); #1;
        check("ready_pulse", {30'd0, cpu_ready, bus_err}, 32'd0);
        check("rdata_held",  cpu_rdata, held);
        $display("txn addr=%h slot=%0d lat=%0d wstrb=%h ready@%0d err=%0d rdata=%h errcnt=%0d",
                 addr, s, lat, wstrb, got_cyc, bus_err, cpu_rdata, err_count);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ready"},  {31'd0, cpu_ready}, 32'd0);
        check({tag, "_rdata"},  cpu_rdata, 32'd0);
        check({tag, "_pvalid"}, {31'd0, per_valid}, 32'd0);
        check({tag, "_pen"},    {28'd0, per_enable}, 32'd0);
        check({tag, "_pinstr"}, {31'd0, per_instr}, 32'd0);
        check({tag, "_pwstrb"}, {28'd0, per_wstrb}, 32'd0);
        check({tag, "_pwdata"}, per_wdata, 32'd0);
        check({tag, "_paddr"},  per_addr, 32'd0);
        check({tag, "_buserr"}, {31'd0, bus_err}, 32'd0);
        check({tag, "_erradr"}, err_addr, 32'd0);
        check({tag, "_errcnt"}, {24'd0, err_count}, 32'd0);
    endtask

    initial begin
        logic [31:0] a;
        for (int i = 0; i < 4; i++) begin
            slv_lat[i]  = 1;
            slv_data[i] = 32'h0;
            slv_cnt[i]  = 0;
        end
        reset     = 1'b1;
        cpu_valid = 1'b0;
        cpu_instr = 1'b0;
        cpu_wstrb = 4'h0;
        cpu_wdata = 32'h0;
        cpu_addr  = 32'h0;
        exp_rdata     = 32'h0;
        exp_err_addr  = 32'h0;
        exp_err_count = 0;

        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        reset = 1'b0;
        @(posedge clk); #1;

        // Write to slot 0 with a one-cycle slave
        slv_data[0] = 32'h5555_0000;
        do_txn(32'h0200_0004, 4'hF, 32'h0000_1234, 1'b0);
        // Read from slot 0
        slv_data[0] = 32'h0000_00A5;
        do_txn(32'h0200_0004, 4'h0, 32'h0, 1'b0);
        // Unpopulated slot 2
        do_txn(32'h0200_0200, 4'h0, 32'h0, 1'b0);
        // Hung slave in populated slot 0
        slv_lat[0] = 0;
        do_txn(32'h0200_0010, 4'h0, 32'h0, 1'b1);
        // Slave answering exactly on the timeout edge: ready wins
        slv_lat[0]  = TMO;
        slv_data[0] = 32'h0BAD_F00D;
        do_txn(32'h0200_0020, 4'h3, 32'hCAFE_0001, 1'b0);
        // Outside the window
        do_miss(32'h0000_1000);

        // Random mix
        for (int n = 0; n < 150; n++) begin
            for (int i = 0; i < 4; i++) begin
                slv_lat[i]  = $urandom_range(0, 6);
                slv_data[i] = $urandom;
            end
            if ($urandom_range(0, 9) == 0) begin
                a = {8'h10, 24'($urandom)};
                if (is_hit(a)) a[31] = 1'b1;
                do_miss(a);
            end else begin
                a = BASE | (32'($urandom_range(0, 3)) << SBITS) | 32'($urandom_range(0, 255));
                do_txn(a, 4'($urandom), $urandom, 1'($urandom));
            end
        end

        // Error counter saturation through repeated timeouts
        slv_lat[0] = 0;
        for (int n = 0; n < 256; n++) begin
            do_txn(32'h0200_0000 | 32'(n & 8'hFC), 4'h0, 32'h0, 1'b0);
        end
        check("err_sat", {24'd0, err_count}, 32'd255);

        // Reset in the middle of an access
        cpu_addr  = 32'h0200_0008;
        cpu_wstrb = 4'hF;
        cpu_wdata = 32'h1111_2222;
        cpu_instr = 1'b1;
        cpu_valid = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("mid_pvalid", {31'd0, per_valid}, 32'd1);
        reset     = 1'b1;
        cpu_valid = 1'b0;
        @(posedge clk); #1;
        check_all_zero("midrst");
        reset = 1'b0;
        exp_rdata     = 32'h0;
        exp_err_addr  = 32'h0;
        exp_err_count = 0;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            check("post_rst_quiet", {31'd0, cpu_ready}, 32'd0);
        end
        slv_lat[0]  = 1;
        slv_data[0] = 32'h7777_8888;
        do_txn(32'h0200_0004, 4'hF, 32'hABCD_0123, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/periph_bus_bridge.md
Name: periph_bus_bridge

Overview:
- Address decoder and handshake bridge between the picorv32 native memory port and up to four memory-mapped peripherals (timer, UART, GPIO, ...).
- Decodes one address window and drives a one-hot per-slot enable.
- Forwards a registered request and returns the selected slot's read data to the CPU.
- Terminates accesses to unpopulated slots and hung slaves with an error response, so the CPU never stalls forever.

Parameters:
- BASE_ADDR, 32'h0200_0000: window base; must be aligned to 4*2^SLOT_BITS.
- SLOT_BITS, 8: log2 of bytes per slot; the window spans 4 slots.
- SLOT_MASK, 4'b0001: populated slots; bit i = slot i present.
- TIMEOUT, 255: maximum ACCESS cycles before error termination; range 1..255.
- ERR_DATA, 32'hDEAD_BEEF: read data returned on error responses.

Ports:
- clk  in  1  clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- cpu_valid  in  1  CPU request valid.
- cpu_instr  in  1  instruction fetch flag; forwarded unchanged.
- cpu_wstrb  in  4  byte write strobes; 0 = read.
- cpu_wdata  in  32  write data.
- cpu_addr  in  32  byte address.
- cpu_ready  out  1  one-cycle completion pulse to CPU.
- cpu_rdata  out  32  registered read data.
- per_valid  out  1  request valid to peripherals.
- per_enable  out  4  one-hot slot select.
- per_instr  out  1  registered cpu_instr.
- per_wstrb  out  4  registered strobes.
- per_wdata  out  32  registered write data.
- per_addr  out  32  registered address.
- per_ready  in  4  per-slot ready.
- per_rdata  in  128  per-slot read data; slot i on bits [32i+31:32i].
- bus_err  out  1  one-cycle pulse on every error termination.
- err_addr  out  32  address of the most recent error.
- err_count  out  8  error counter; saturates at 255.

Behaviour:
- Reset (synchronous, active-high): state IDLE. At the next edge, all of the following are 0:
  - cpu_ready, cpu_rdata, per_valid, per_enable, per_instr, per_wstrb, per_wdata, per_addr;
  - bus_err, err_addr, err_count, timeout counter.
  - Reset asserted mid-access aborts the access; no cpu_ready is issued.
- Window hit: cpu_addr[31:SLOT_BITS+2] == BASE_ADDR[31:SLOT_BITS+2]. Slot index s = cpu_addr[SLOT_BITS+1:SLOT_BITS].
- Misses are ignored entirely: the bridge stays IDLE with all outputs low, because another decoder owns them.
- FSM states: IDLE, ACCESS, RESP, ERR.
- IDLE, taking a request:
  - Condition: cpu_valid & hit & !cpu_ready.
  - Capture cpu_addr/wstrb/wdata/instr into the per_* registers.
  - If SLOT_MASK[s]: go to ACCESS, with per_valid=1 and per_enable=1<<s from the next cycle; clear the timeout counter.
  - Else: go to ERR.
- ACCESS:
  - per_* outputs held stable; timeout counter increments each cycle.
  - If per_ready[s]: latch per_rdata slot s into cpu_rdata (for writes too), drop per_valid/per_enable, go to RESP.
  - Otherwise, on the cycle where the counter reaches TIMEOUT: drop per_valid/per_enable, go to ERR.
  - per_ready from non-selected slots is ignored.
- RESP: cpu_ready=1 for exactly one cycle, then IDLE.
- ERR: for one cycle, cpu_ready=1 and bus_err=1; cpu_rdata=ERR_DATA; err_addr=per_addr; err_count increments (saturating at 255, no wrap); then IDLE.
- Latency, cycles from cpu_valid sample (cycle 0) to cpu_ready:
  - Slave with one-cycle ready (timer): cycle 3.
  - Unpopulated slot: cycle 1.
  - Timeout: cycle TIMEOUT+2.
- cpu_rdata is held between responses and changes only in the RESP or ERR entry cycle.
- After RESP/ERR the CPU drops cpu_valid.
  - A cpu_valid still high in the cycle cpu_ready=1 is not a new request (guarded by !cpu_ready).
  - Back-to-back accesses start from IDLE, so the minimum spacing is one IDLE cycle. This lets a slave's trailing ready flush before the next ACCESS.
- per_ready arriving on the same edge as the timeout limit: ready wins, giving a normal RESP with no error.
- Write strobes are passed through unchanged; partial writes are the slave's concern.

Test Plan:
1. Write to slot 0: cpu_addr=0x0200_0004, wstrb=0xF, wdata=0x1234, model slave ready 1 cycle after per_valid -> per_enable=4'b0001 and per_addr=0x0200_0004 at cycle 1; cpu_ready pulse at cycle 3; bus_err=0.
2. Read from slot 0: slave drives per_rdata[31:0]=0x0000_00A5 -> cpu_rdata=0x0000_00A5 on the cpu_ready cycle, held after cpu_valid drops.
3. Unpopulated slot: read 0x0200_0200 with SLOT_MASK=4'b0001 -> per_valid never asserts; cpu_ready and bus_err at cycle 1; cpu_rdata=0xDEAD_BEEF; err_addr=0x0200_0200; err_count=1.
4. Timeout: populated slot, per_ready stuck 0, TIMEOUT=4 -> per_valid high for 4 cycles, then ERR; cpu_ready at cycle 6; err_count increments. Repeat 256 times -> err_count stays 255.
5. Outside window: cpu_valid with addr 0x0000_1000 for 20 cycles -> cpu_ready, per_valid and bus_err all stay 0.
6. Reset mid-ACCESS: assert reset while per_valid=1 -> all outputs 0 at the next edge, no cpu_ready; a fresh request then completes normally at cycle 3.
